// File: rtl/mm_arb_pkg.sv
// Shared types and default widths for the Montgomery-multiplier arbiter.
package mm_arb_pkg;

   localparam int unsigned DEF_WIDTH = 256;
   localparam int unsigned DEF_MP_W  = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } state_e;

endpackage : mm_arb_pkg

// File: rtl/mm_arbiter_if.sv
// Arbiter-to-multiplier-core link: latched operands, start/abort pulses, done/result back.
interface mm_arbiter_if
   import mm_arb_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH,
   parameter int unsigned MP_W  = DEF_MP_W
);

   logic             core_start;
   logic             core_abort;
   logic [WIDTH-1:0] core_a;
   logic [WIDTH-1:0] core_b;
   logic [WIDTH-1:0] core_mod;
   logic [MP_W-1:0]  core_mp;
   logic             core_done;
   logic [WIDTH-1:0] core_result;

   modport master (
      output core_start, core_abort, core_a, core_b, core_mod, core_mp,
      input  core_done, core_result
   );

   modport slave (
      input  core_start, core_abort, core_a, core_b, core_mod, core_mp,
      output core_done, core_result
   );

endinterface : mm_arbiter_if

// File: rtl/mm_arbiter_rr_picker.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping modulo N_REQ.
module rr_picker #(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned PTR_W = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req_i,
   input  logic [PTR_W-1:0] ptr_i,
   output logic [N_REQ-1:0] gnt_c_o,
   output logic [PTR_W-1:0] idx_c_o,
   output logic             valid_c_o
);

   logic [PTR_W-1:0] cand;

   // Scan from the farthest offset down so the nearest request to ptr wins.
   always_comb begin
      idx_c_o   = '0;
      valid_c_o = 1'b0;
      cand      = '0;
      for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
         cand = PTR_W'((int'(ptr_i) + k) % int'(N_REQ));
         if (req_i[cand]) begin
            idx_c_o   = cand;
            valid_c_o = 1'b1;
         end
      end
   end

   assign gnt_c_o = valid_c_o ? (N_REQ'(1) << idx_c_o) : '0;

endmodule : rr_picker

// File: rtl/mm_arbiter.sv
// Round-robin sequencer sharing one Montgomery multiplier among N_REQ requesters.
// Optional watchdog on the core: define MM_ARB_TIMEOUT_EN.
module mm_arbiter
   import mm_arb_pkg::*;
#(
   parameter int unsigned N_REQ   = 4,
   parameter int unsigned WIDTH   = DEF_WIDTH,
   parameter int unsigned MP_W    = DEF_MP_W,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic [N_REQ-1:0]       req,
   input  logic [N_REQ*WIDTH-1:0] req_a,
   input  logic [N_REQ*WIDTH-1:0] req_b,
   input  logic [N_REQ*WIDTH-1:0] req_mod,
   input  logic [N_REQ*MP_W-1:0]  req_mp,
   output logic [N_REQ-1:0]       grant,
   output logic [N_REQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]       rsp_data,
   output logic                   rsp_err,
   output logic                   busy,
   mm_arbiter_if.master           core
);

   localparam int unsigned PTR_W = $clog2(N_REQ);

   state_e           state_q, state_d;
   logic [N_REQ-1:0] grant_q, grant_d, rsp_valid_q, rsp_valid_d;
   logic [PTR_W-1:0] ptr_q, ptr_d, idx_q, idx_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, mod_q, mod_d, rsp_data_q, rsp_data_d;
   logic [MP_W-1:0]  mp_q, mp_d;
   logic             start_q, start_d, abort_q, abort_d, err_q, err_d, busy_q, busy_d;
   logic             timeout_c;

   logic [N_REQ-1:0][WIDTH-1:0] a_arr, b_arr, mod_arr;
   logic [N_REQ-1:0][MP_W-1:0]  mp_arr;
   logic [N_REQ-1:0]            pick_gnt_c;
   logic [PTR_W-1:0]            pick_idx_c;
   logic                        pick_valid_c;

   assign a_arr   = req_a;
   assign b_arr   = req_b;
   assign mod_arr = req_mod;
   assign mp_arr  = req_mp;

   rr_picker #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_picker (
      .req_i     (req),
      .ptr_i     (ptr_q),
      .gnt_c_o   (pick_gnt_c),
      .idx_c_o   (pick_idx_c),
      .valid_c_o (pick_valid_c)
   );

`ifdef MM_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Counts WAIT cycles; cleared while the start pulse is out.
   always_comb begin
      cnt_d = cnt_q;
      if (state_q == ISSUE)     cnt_d = '0;
      else if (state_q == WAIT) cnt_d = cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) cnt_q <= '0;
      else       cnt_q <= cnt_d;
   end

   assign timeout_c = (state_q == WAIT) && (cnt_q == CNT_W'(TIMEOUT - 1));
`else
   // TIMEOUT only matters when the watchdog is built in.
   logic unused_timeout;
   assign unused_timeout = (TIMEOUT != 0);
   assign timeout_c      = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      idx_d       = idx_q;
      ptr_d       = ptr_q;
      a_d         = a_q;
      b_d         = b_q;
      mod_d       = mod_q;
      mp_d        = mp_q;
      rsp_data_d  = rsp_data_q;
      err_d       = err_q;
      rsp_valid_d = '0;
      start_d     = 1'b0;
      abort_d     = 1'b0;
      unique case (state_q)
         IDLE: if (pick_valid_c) begin
            state_d = ISSUE;
            grant_d = pick_gnt_c;
            idx_d   = pick_idx_c;
            a_d     = a_arr[pick_idx_c];
            b_d     = b_arr[pick_idx_c];
            mod_d   = mod_arr[pick_idx_c];
            mp_d    = mp_arr[pick_idx_c];
            start_d = 1'b1;
         end
         ISSUE: state_d = WAIT;
         // A done pulse coinciding with the timeout takes priority.
         WAIT: if (core.core_done) begin
            state_d     = RESP;
            rsp_data_d  = core.core_result;
            err_d       = 1'b0;
            rsp_valid_d = grant_q;
         end else if (timeout_c) begin
            state_d     = RESP;
            rsp_data_d  = '0;
            err_d       = 1'b1;
            abort_d     = 1'b1;
            rsp_valid_d = grant_q;
         end
         RESP: begin
            state_d = IDLE;
            grant_d = '0;
            err_d   = 1'b0;
            ptr_d   = (idx_q == PTR_W'(N_REQ - 1)) ? '0 : idx_q + PTR_W'(1);
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= IDLE;
         grant_q     <= '0;
         idx_q       <= '0;
         ptr_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         mod_q       <= '0;
         mp_q        <= '0;
         rsp_data_q  <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= '0;
         start_q     <= 1'b0;
         abort_q     <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         idx_q       <= idx_d;
         ptr_q       <= ptr_d;
         a_q         <= a_d;
         b_q         <= b_d;
         mod_q       <= mod_d;
         mp_q        <= mp_d;
         rsp_data_q  <= rsp_data_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         start_q     <= start_d;
         abort_q     <= abort_d;
         busy_q      <= busy_d;
      end
   end

   assign grant           = grant_q;
   assign rsp_valid       = rsp_valid_q;
   assign rsp_data        = rsp_data_q;
   assign rsp_err         = err_q;
   assign busy            = busy_q;
   assign core.core_start = start_q;
   assign core.core_abort = abort_q;
   assign core.core_a     = a_q;
   assign core.core_b     = b_q;
   assign core.core_mod   = mod_q;
   assign core.core_mp    = mp_q;

endmodule : mm_arbiter

// File: tb/tb_mm_arbiter.sv
// Directed bench for mm_arbiter; the bench itself plays the multiplier core.
module tb_mm_arbiter;
   import mm_arb_pkg::*;

   localparam int unsigned N   = 4;
   localparam int unsigned W   = 64;
   localparam int unsigned MPW = 32;

   logic             clk = 1'b0;
   logic             rstn = 1'b0;
   logic [N-1:0]     req = '0;
   logic [N*W-1:0]   req_a = '0, req_b = '0, req_mod = '0;
   logic [N*MPW-1:0] req_mp = '0;
   logic [N-1:0]     grant, rsp_valid;
   logic [W-1:0]     rsp_data;
   logic             rsp_err, busy;
   logic             core_done = 1'b0;
   logic [W-1:0]     core_result = '0;

   int n_checks = 0;
   int n_fail   = 0;

   mm_arbiter_if #(.WIDTH(W), .MP_W(MPW)) core_if ();
   assign core_if.core_done   = core_done;
   assign core_if.core_result = core_result;

   mm_arbiter #(.N_REQ(N), .WIDTH(W), .MP_W(MPW), .TIMEOUT(16)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .req       (req),
      .req_a     (req_a),
      .req_b     (req_b),
      .req_mod   (req_mod),
      .req_mp    (req_mp),
      .grant     (grant),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err),
      .busy      (busy),
      .core      (core_if.master)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({grant, rsp_valid, rsp_err, busy, core_if.core_start, core_if.core_abort} !== '0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got grant=%b rsp_valid=%b err=%b busy=%b start=%b abort=%b, want all 0",
                  grant, rsp_valid, rsp_err, busy, core_if.core_start, core_if.core_abort);
      end
      n_checks++;
      if ({rsp_data, core_if.core_a, core_if.core_b, core_if.core_mod, core_if.core_mp} !== '0) begin
         n_fail++;
         $display("FAIL reset_data: got rsp_data=%h a=%h b=%h mod=%h mp=%h, want all 0",
                  rsp_data, core_if.core_a, core_if.core_b, core_if.core_mod, core_if.core_mp);
      end
      rstn = 1'b1;
      tick();
   endtask

   task automatic test_single();
      int starts = 0;
      int early  = 0;
      req_a[0 +: W]   = 64'd3;
      req_b[0 +: W]   = 64'd5;
      req_mod[0 +: W] = 64'd97;
      req_mp[0 +: MPW] = 32'h1234_5678;
      req = 4'b0001;                       // request cycle r
      tick();                              // r+1: ISSUE
      n_checks++;
      if (grant !== 4'b0001 || core_if.core_start !== 1'b1 || busy !== 1'b1) begin
         n_fail++;
         $display("FAIL single_issue: got grant=%b start=%b busy=%b, want 0001 1 1", grant, core_if.core_start, busy);
      end
      n_checks++;
      if (core_if.core_a !== 64'd3 || core_if.core_b !== 64'd5 || core_if.core_mod !== 64'd97 ||
          core_if.core_mp !== 32'h1234_5678) begin
         n_fail++;
         $display("FAIL single_operands: got a=%0d b=%0d mod=%0d mp=%h, want 3 5 97 12345678",
                  core_if.core_a, core_if.core_b, core_if.core_mod, core_if.core_mp);
      end
      for (int c = 2; c <= 22; c++) begin   // WAIT cycles r+2 .. r+22
         tick();
         if (core_if.core_start) starts++;
         if (rsp_valid != '0) early++;
      end
      core_done = 1'b1;                     // done in cycle r+22
      core_result = 64'h2A;
      tick();                              // r+23
      core_done = 1'b0;
      req = '0;
      n_checks++;
      if (starts != 0 || early != 0) begin
         n_fail++;
         $display("FAIL single_wait: got extra starts=%0d early rsp=%0d, want 0 0", starts, early);
      end
      n_checks++;
      if (rsp_valid !== 4'b0001 || rsp_data !== 64'h2A || rsp_err !== 1'b0) begin
         n_fail++;
         $display("FAIL single_rsp: got rsp_valid=%b data=%h err=%b at r+23, want 0001 2a 0", rsp_valid, rsp_data, rsp_err);
      end
      tick();                              // r+24: IDLE
      n_checks++;
      if (rsp_valid !== '0 || grant !== '0 || busy !== 1'b0 || rsp_data !== 64'h2A) begin
         n_fail++;
         $display("FAIL single_after: got rsp_valid=%b grant=%b busy=%b data=%h, want 0000 0000 0 2a",
                  rsp_valid, grant, busy, rsp_data);
      end
   endtask

   // ptr=1 on entry; requester 2 is served here, leaving ptr=3.
   task automatic test_done_ignored();
      core_done = 1'b1;
      core_result = 64'h77;
      tick();
      core_done = 1'b0;
      n_checks++;
      if (busy !== 1'b0 || rsp_valid !== '0 || grant !== '0 || rsp_data !== 64'h2A) begin
         n_fail++;
         $display("FAIL done_idle: got busy=%b rsp_valid=%b grant=%b data=%h, want 0 0000 0000 2a",
                  busy, rsp_valid, grant, rsp_data);
      end
      req_a[2*W +: W] = 64'h44;
      req = 4'b0100;
      tick();                              // ISSUE
      core_done = 1'b1;
      core_result = 64'h99;
      tick();                              // WAIT 1
      core_done = 1'b0;
      n_checks++;
      if (rsp_valid !== '0 || busy !== 1'b1 || grant !== 4'b0100 || rsp_data !== 64'h2A) begin
         n_fail++;
         $display("FAIL done_issue: got rsp_valid=%b busy=%b grant=%b data=%h, want 0000 1 0100 2a",
                  rsp_valid, busy, grant, rsp_data);
      end
      core_done = 1'b1;
      core_result = 64'h55;
      tick();                              // RESP
      core_done = 1'b0;
      req = '0;
      n_checks++;
      if (rsp_valid !== 4'b0100 || rsp_data !== 64'h55) begin
         n_fail++;
         $display("FAIL done_resp: got rsp_valid=%b data=%h, want 0100 55", rsp_valid, rsp_data);
      end
      tick();
   endtask

   // ptr=3 on entry so requester 3 wins first; after reset ptr=0 picks requester 1.
   task automatic test_mid_reset();
      req_a[1*W +: W] = 64'h11;
      req_a[3*W +: W] = 64'h33;
      req = 4'b1010;
      tick();
      n_checks++;
      if (grant !== 4'b1000 || core_if.core_a !== 64'h33) begin
         n_fail++;
         $display("FAIL mreset_pre: got grant=%b a=%h, want 1000 33", grant, core_if.core_a);
      end
      tick();                              // WAIT
      #2 rstn = 1'b0;
      #1;
      n_checks++;
      if ({grant, rsp_valid, busy, core_if.core_start} !== '0 || rsp_data !== '0 || core_if.core_a !== '0) begin
         n_fail++;
         $display("FAIL mreset_clear: got grant=%b rsp_valid=%b busy=%b data=%h a=%h, want all 0",
                  grant, rsp_valid, busy, rsp_data, core_if.core_a);
      end
      tick();
      rstn = 1'b1;
      tick();
      n_checks++;
      if (grant !== 4'b0010 || core_if.core_a !== 64'h11 || core_if.core_start !== 1'b1) begin
         n_fail++;
         $display("FAIL mreset_regrant: got grant=%b a=%h start=%b, want 0010 11 1", grant, core_if.core_a, core_if.core_start);
      end
      tick();
      core_done = 1'b1;
      core_result = 64'h66;
      tick();
      core_done = 1'b0;
      req = '0;
      n_checks++;
      if (rsp_valid !== 4'b0010 || rsp_data !== 64'h66) begin
         n_fail++;
         $display("FAIL mreset_rsp: got rsp_valid=%b data=%h, want 0010 66", rsp_valid, rsp_data);
      end
      tick();
   endtask

   // ptr=2 after requester 1 was served: req=0011 must wrap to requester 0.
   task automatic test_wrap();
      req_a[0*W +: W] = 64'hA0;
      req_a[1*W +: W] = 64'hA1;
      req = 4'b0011;
      tick();
      n_checks++;
      if (grant !== 4'b0001 || core_if.core_a !== 64'hA0) begin
         n_fail++;
         $display("FAIL wrap_grant: got grant=%b a=%h, want 0001 a0", grant, core_if.core_a);
      end
      tick();
      core_done = 1'b1;
      core_result = 64'h1;
      tick();
      core_done = 1'b0;
      tick();                              // IDLE with req still high
      n_checks++;
      if (grant !== '0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL wrap_gap: got grant=%b busy=%b, want 0000 0", grant, busy);
      end
      tick();
      n_checks++;
      if (grant !== 4'b0010 || core_if.core_a !== 64'hA1) begin
         n_fail++;
         $display("FAIL wrap_next: got grant=%b a=%h, want 0010 a1", grant, core_if.core_a);
      end
      tick();
      core_done = 1'b1;
      core_result = 64'h2;
      tick();
      core_done = 1'b0;
      req = '0;
      tick();
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_g;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      for (int i = 0; i < int'(N); i++) req_a[i*W +: W] = 64'h100 + 64'(i);
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         exp_g = 4'b0001 << (k % 4);
         tick();                           // ISSUE
         n_checks++;
         if (grant !== exp_g || core_if.core_a !== 64'h100 + 64'(k % 4) || core_if.core_start !== 1'b1) begin
            n_fail++;
            $display("FAIL rr_grant%0d: got grant=%b a=%h start=%b, want %b %h 1",
                     k, grant, core_if.core_a, core_if.core_start, exp_g, 64'h100 + 64'(k % 4));
         end
         tick();                           // WAIT 1
         core_done = 1'b1;
         core_result = 64'h200 + 64'(k);
         tick();                           // RESP
         core_done = 1'b0;
         n_checks++;
         if (rsp_valid !== exp_g || rsp_data !== 64'h200 + 64'(k)) begin
            n_fail++;
            $display("FAIL rr_rsp%0d: got rsp_valid=%b data=%h, want %b %h", k, rsp_valid, rsp_data, exp_g, 64'h200 + 64'(k));
         end
         tick();                           // IDLE
      end
      req = '0;
      tick();
      n_checks++;
      if (busy !== 1'b0 || grant !== '0) begin
         n_fail++;
         $display("FAIL rr_end: got busy=%b grant=%b, want 0 0000", busy, grant);
      end
   endtask

`ifdef MM_ARB_TIMEOUT_EN
   task automatic test_timeout();
      int  cyc  = 0;
      bit  seen = 1'b0;
      req = 4'b0001;
      tick();                              // ISSUE
      while (!seen && cyc < 40) begin
         tick();
         cyc++;
         if (rsp_valid != '0) seen = 1'b1;
      end
      req = '0;
      n_checks++;
      if (!seen || cyc != 17) begin
         n_fail++;
         $display("FAIL timeout_when: got seen=%0d after %0d cycles, want 1 after 17", seen, cyc);
      end
      n_checks++;
      if (core_if.core_abort !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0 || rsp_valid !== 4'b0001) begin
         n_fail++;
         $display("FAIL timeout_rsp: got abort=%b err=%b data=%h rsp_valid=%b, want 1 1 0 0001",
                  core_if.core_abort, rsp_err, rsp_data, rsp_valid);
      end
      tick();
      n_checks++;
      if (core_if.core_abort !== 1'b0 || rsp_err !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_after: got abort=%b err=%b busy=%b, want 0 0 0", core_if.core_abort, rsp_err, busy);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_done_ignored();
      test_mid_reset();
      test_wrap();
      test_round_robin();
`ifdef MM_ARB_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_mm_arbiter
